// File: rtl/tlb_cache_mt.sv
// tlb_cache_mt: multi-threaded, fully associative instruction TLB.
// Translates a virtual PC to a physical address in the same cycle as the request. Each hardware
// thread owns a private partition of entries. In single-threaded mode every thread maps onto
// partition 0. Entries are installed by OS write requests and replaced round-robin per partition.
//
// Ports:
//   clock             - sole clock, rising edge
//   reset             - synchronous, active-high; clears valid bits and victim pointers
//   mt_mode           - 0 = single-threaded (shared partition 0), 1 = multi-threaded
//   req_valid         - lookup request
//   req_virt_addr     - virtual address to translate
//   req_thread_id     - requesting thread
//   priv_mode         - 0 = user (translate), 1 = supervisor (bypass)
//   rsp_valid         - response valid (combinational)
//   tlb_miss          - translation not found, qualified by rsp_valid
//   rsp_phy_addr      - physical address
//   writePriv         - write permission of the matching page
//   new_tlb_entry     - install request
//   new_tlb_thread_id - owning thread of the new entry
//   new_tlb_info      - {virt_page, phy_page, write_priv}, MSB first
module tlb_cache_mt #(
  parameter int unsigned THR_PER_CORE      = 4,
  parameter int unsigned THR_ID_WIDTH      = 2,
  parameter int unsigned ENTRIES_PER_THR   = 4,
  parameter int unsigned VADDR_WIDTH       = 32,
  parameter int unsigned PADDR_WIDTH       = 20,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  localparam int unsigned VPN_WIDTH        = VADDR_WIDTH - PAGE_OFFSET_WIDTH,
  localparam int unsigned PPN_WIDTH        = PADDR_WIDTH - PAGE_OFFSET_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           mt_mode,
  input  logic                           req_valid,
  input  logic [VADDR_WIDTH-1:0]         req_virt_addr,
  input  logic [THR_ID_WIDTH-1:0]        req_thread_id,
  input  logic                           priv_mode,
  output logic                           rsp_valid,
  output logic                           tlb_miss,
  output logic [PADDR_WIDTH-1:0]         rsp_phy_addr,
  output logic                           writePriv,
  input  logic                           new_tlb_entry,
  input  logic [THR_ID_WIDTH-1:0]        new_tlb_thread_id,
  input  logic [VPN_WIDTH+PPN_WIDTH:0]   new_tlb_info
);

  localparam int unsigned IDX_W = $clog2(ENTRIES_PER_THR);

  logic                 r_valid  [THR_PER_CORE][ENTRIES_PER_THR];
  logic [VPN_WIDTH-1:0] r_vpn    [THR_PER_CORE][ENTRIES_PER_THR];
  logic [PPN_WIDTH-1:0] r_ppn    [THR_PER_CORE][ENTRIES_PER_THR];
  logic                 r_wp     [THR_PER_CORE][ENTRIES_PER_THR];
  logic [IDX_W-1:0]     r_victim [THR_PER_CORE];

  logic [THR_ID_WIDTH-1:0] w_req_thr;
  logic [THR_ID_WIDTH-1:0] w_new_thr;
  logic [VPN_WIDTH-1:0]    w_req_vpn;
  logic                    w_hit;
  logic [PPN_WIDTH-1:0]    w_hit_ppn;
  logic                    w_hit_wp;

  logic [VPN_WIDTH-1:0]    w_new_vpn;
  logic [PPN_WIDTH-1:0]    w_new_ppn;
  logic                    w_new_wp;
  logic                    w_ins_match;
  logic [IDX_W-1:0]        w_ins_idx;

  // Single-threaded mode folds every thread onto partition 0.
  assign w_req_thr = mt_mode ? req_thread_id : '0;
  assign w_new_thr = mt_mode ? new_tlb_thread_id : '0;
  assign w_req_vpn = req_virt_addr[VADDR_WIDTH-1:PAGE_OFFSET_WIDTH];

  assign w_new_vpn = new_tlb_info[VPN_WIDTH+PPN_WIDTH:PPN_WIDTH+1];
  assign w_new_ppn = new_tlb_info[PPN_WIDTH:1];
  assign w_new_wp  = new_tlb_info[0];

  // Lookup CAM: at most one entry can match, so the hit data is simply OR-combined.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_ppn = '0;
    w_hit_wp  = 1'b0;
    for (int e = 0; e < ENTRIES_PER_THR; e++) begin
      if (r_valid[w_req_thr][e] && (r_vpn[w_req_thr][e] == w_req_vpn)) begin
        w_hit     = 1'b1;
        w_hit_ppn = w_hit_ppn | r_ppn[w_req_thr][e];
        w_hit_wp  = w_hit_wp | r_wp[w_req_thr][e];
      end
    end
  end

  // Install target: an existing entry with the same VPN, otherwise the victim slot.
  always_comb begin
    w_ins_match = 1'b0;
    w_ins_idx   = r_victim[w_new_thr];
    for (int e = 0; e < ENTRIES_PER_THR; e++) begin
      if (r_valid[w_new_thr][e] && (r_vpn[w_new_thr][e] == w_new_vpn)) begin
        w_ins_match = 1'b1;
        w_ins_idx   = IDX_W'(e);
      end
    end
  end

  always_comb begin
    rsp_valid    = 1'b0;
    tlb_miss     = 1'b0;
    rsp_phy_addr = '0;
    writePriv    = 1'b0;
    if (req_valid && !reset) begin
      rsp_valid = 1'b1;
      if (priv_mode) begin
        rsp_phy_addr = req_virt_addr[PADDR_WIDTH-1:0];
        writePriv    = 1'b1;
      end else if (w_hit) begin
        rsp_phy_addr = {w_hit_ppn, req_virt_addr[PAGE_OFFSET_WIDTH-1:0]};
        writePriv    = w_hit_wp;
      end else begin
        tlb_miss = 1'b1;
      end
    end
  end

  // Entry payload is not reset; only valid bits and victim pointers need a known state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < THR_PER_CORE; t++) begin
        r_victim[t] <= '0;
        for (int e = 0; e < ENTRIES_PER_THR; e++) begin
          r_valid[t][e] <= 1'b0;
        end
      end
    end else if (new_tlb_entry) begin
      r_valid[w_new_thr][w_ins_idx] <= 1'b1;
      r_vpn[w_new_thr][w_ins_idx]   <= w_new_vpn;
      r_ppn[w_new_thr][w_ins_idx]   <= w_new_ppn;
      r_wp[w_new_thr][w_ins_idx]    <= w_new_wp;
      if (!w_ins_match) begin
        r_victim[w_new_thr] <= r_victim[w_new_thr] + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tlb_cache_mt.sv
module tb_tlb_cache_mt;

  logic        clock;
  logic        reset;
  logic        mt_mode;
  logic        req_valid;
  logic [31:0] req_virt_addr;
  logic [1:0]  req_thread_id;
  logic        priv_mode;
  logic        rsp_valid;
  logic        tlb_miss;
  logic [19:0] rsp_phy_addr;
  logic        writePriv;
  logic        new_tlb_entry;
  logic [1:0]  new_tlb_thread_id;
  logic [28:0] new_tlb_info;

  int n_checks;
  int n_errors;

  // Response packed as {rsp_valid, tlb_miss, writePriv, rsp_phy_addr}.
  logic [22:0] obs;
  assign obs = {rsp_valid, tlb_miss, writePriv, rsp_phy_addr};

  localparam logic [22:0] RspIdle = 23'h0;
  localparam logic [22:0] RspMiss = {1'b1, 1'b1, 1'b0, 20'h0};

  tlb_cache_mt dut (
    .clock             (clock),
    .reset             (reset),
    .mt_mode           (mt_mode),
    .req_valid         (req_valid),
    .req_virt_addr     (req_virt_addr),
    .req_thread_id     (req_thread_id),
    .priv_mode         (priv_mode),
    .rsp_valid         (rsp_valid),
    .tlb_miss          (tlb_miss),
    .rsp_phy_addr      (rsp_phy_addr),
    .writePriv         (writePriv),
    .new_tlb_entry     (new_tlb_entry),
    .new_tlb_thread_id (new_tlb_thread_id),
    .new_tlb_info      (new_tlb_info)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [22:0] hit_rsp(input logic [7:0] ppn, input logic wp,
                                          input logic [11:0] off);
    return {1'b1, 1'b0, wp, ppn, off};
  endfunction

  // Drive a lookup at the falling edge and settle the combinational response.
  task automatic lookup(input logic [31:0] va, input logic [1:0] thr, input logic priv);
    @(negedge clock);
    req_valid     = 1'b1;
    req_virt_addr = va;
    req_thread_id = thr;
    priv_mode     = priv;
    #1;
  endtask

  task automatic install(input logic [1:0] thr, input logic [19:0] vpn, input logic [7:0] ppn,
                         input logic wp);
    @(negedge clock);
    new_tlb_entry     = 1'b1;
    new_tlb_thread_id = thr;
    new_tlb_info      = {vpn, ppn, wp};
    @(posedge clock);
    #1;
    new_tlb_entry = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b1;
    req_virt_addr = 32'h0000_1234;
    req_thread_id = 2'd0;
    priv_mode = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (obs !== RspIdle) begin
      n_errors++;
      $display("FAIL reset_outputs got=%h want=%h", obs, RspIdle);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    n_checks++;
    if (obs !== RspIdle) begin
      n_errors++;
      $display("FAIL idle_after_reset got=%h want=%h", obs, RspIdle);
    end
    lookup(32'h0000_1234, 2'd0, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL empty_user_miss got=%h want=%h", obs, RspMiss);
    end
  endtask

  task automatic test_basic_hit();
    install(2'd0, 20'h00001, 8'h2A, 1'b1);
    lookup(32'h0000_1234, 2'd0, 1'b0);
    n_checks++;
    if (obs !== hit_rsp(8'h2A, 1'b1, 12'h234)) begin
      n_errors++;
      $display("FAIL basic_hit got=%h want=%h", obs, hit_rsp(8'h2A, 1'b1, 12'h234));
    end
  endtask

  task automatic test_thread_isolation();
    lookup(32'h0000_1234, 2'd1, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL other_thread_miss got=%h want=%h", obs, RspMiss);
    end
    mt_mode = 1'b0;
    lookup(32'h0000_1234, 2'd3, 1'b0);
    n_checks++;
    if (obs !== hit_rsp(8'h2A, 1'b1, 12'h234)) begin
      n_errors++;
      $display("FAIL st_mode_shared_hit got=%h want=%h", obs, hit_rsp(8'h2A, 1'b1, 12'h234));
    end
    // In single-threaded mode an install tagged thread 3 lands in partition 0.
    install(2'd3, 20'h00005, 8'h5C, 1'b0);
    mt_mode = 1'b1;
    lookup(32'h0000_5010, 2'd0, 1'b0);
    n_checks++;
    if (obs !== hit_rsp(8'h5C, 1'b0, 12'h010)) begin
      n_errors++;
      $display("FAIL st_install_to_p0 got=%h want=%h", obs, hit_rsp(8'h5C, 1'b0, 12'h010));
    end
    lookup(32'h0000_5010, 2'd3, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL st_install_not_p3 got=%h want=%h", obs, RspMiss);
    end
  endtask

  task automatic test_supervisor();
    pulse_reset();
    lookup(32'hDEAD_BEEF, 2'd2, 1'b1);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 20'hDBEEF}) begin
      n_errors++;
      $display("FAIL supervisor_bypass got=%h want=%h", obs, {1'b1, 1'b0, 1'b1, 20'hDBEEF});
    end
    req_valid = 1'b0;
    #1;
    n_checks++;
    if (obs !== RspIdle) begin
      n_errors++;
      $display("FAIL no_req_idle got=%h want=%h", obs, RspIdle);
    end
  endtask

  task automatic test_eviction();
    logic [19:0] vpn;
    logic [7:0]  ppn;
    logic [22:0] exp;
    for (int i = 0; i < 5; i++) begin
      vpn = 20'h10 + 20'(i);
      ppn = 8'h40 + 8'(i);
      install(2'd2, vpn, ppn, i[0]);
    end
    lookup({20'h00010, 12'hABC}, 2'd2, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL evict_oldest got=%h want=%h", obs, RspMiss);
    end
    for (int i = 1; i < 5; i++) begin
      vpn = 20'h10 + 20'(i);
      ppn = 8'h40 + 8'(i);
      exp = hit_rsp(ppn, i[0], 12'hABC);
      lookup({vpn, 12'hABC}, 2'd2, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL evict_survivor vpn=%h got=%h want=%h", vpn, obs, exp);
      end
    end
    // Overwrite in place: pointer stays at slot 1 (holding VPN 0x11).
    install(2'd2, 20'h00012, 8'h77, 1'b1);
    lookup({20'h00012, 12'hABC}, 2'd2, 1'b0);
    n_checks++;
    if (obs !== hit_rsp(8'h77, 1'b1, 12'hABC)) begin
      n_errors++;
      $display("FAIL reinstall_update got=%h want=%h", obs, hit_rsp(8'h77, 1'b1, 12'hABC));
    end
    for (int i = 1; i < 5; i++) begin
      if (i == 2) continue;
      vpn = 20'h10 + 20'(i);
      ppn = 8'h40 + 8'(i);
      exp = hit_rsp(ppn, i[0], 12'hABC);
      lookup({vpn, 12'hABC}, 2'd2, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL reinstall_no_evict vpn=%h got=%h want=%h", vpn, obs, exp);
      end
    end
    install(2'd2, 20'h00015, 8'h45, 1'b0);
    lookup({20'h00011, 12'hABC}, 2'd2, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL victim_ptr_held got=%h want=%h", obs, RspMiss);
    end
    lookup({20'h00012, 12'hABC}, 2'd2, 1'b0);
    n_checks++;
    if (obs !== hit_rsp(8'h77, 1'b1, 12'hABC)) begin
      n_errors++;
      $display("FAIL victim_ptr_spared got=%h want=%h", obs, hit_rsp(8'h77, 1'b1, 12'hABC));
    end
    lookup({20'h00015, 12'hABC}, 2'd2, 1'b0);
    n_checks++;
    if (obs !== hit_rsp(8'h45, 1'b0, 12'hABC)) begin
      n_errors++;
      $display("FAIL new_after_wrap got=%h want=%h", obs, hit_rsp(8'h45, 1'b0, 12'hABC));
    end
    lookup({20'h00013, 12'hABC}, 2'd1, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL partition_private got=%h want=%h", obs, RspMiss);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    new_tlb_entry     = 1'b1;
    new_tlb_thread_id = 2'd0;
    new_tlb_info      = {20'h00009, 8'h33, 1'b0};
    req_valid         = 1'b1;
    req_virt_addr     = 32'h0000_9555;
    req_thread_id     = 2'd0;
    priv_mode         = 1'b0;
    #1;
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL same_cycle_miss got=%h want=%h", obs, RspMiss);
    end
    @(negedge clock);
    new_tlb_entry = 1'b0;
    #1;
    n_checks++;
    if (obs !== hit_rsp(8'h33, 1'b0, 12'h555)) begin
      n_errors++;
      $display("FAIL next_cycle_hit got=%h want=%h", obs, hit_rsp(8'h33, 1'b0, 12'h555));
    end
  endtask

  task automatic test_reset_with_install();
    @(negedge clock);
    reset             = 1'b1;
    new_tlb_entry     = 1'b1;
    new_tlb_thread_id = 2'd0;
    new_tlb_info      = {20'h0000A, 8'h11, 1'b1};
    req_valid         = 1'b0;
    @(negedge clock);
    reset         = 1'b0;
    new_tlb_entry = 1'b0;
    lookup(32'h0000_A000, 2'd0, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL reset_drops_install got=%h want=%h", obs, RspMiss);
    end
    lookup(32'h0000_9555, 2'd0, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL reset_flush_p0 got=%h want=%h", obs, RspMiss);
    end
    lookup({20'h00015, 12'h000}, 2'd2, 1'b0);
    n_checks++;
    if (obs !== RspMiss) begin
      n_errors++;
      $display("FAIL reset_flush_p2 got=%h want=%h", obs, RspMiss);
    end
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    mt_mode           = 1'b1;
    new_tlb_entry     = 1'b0;
    new_tlb_thread_id = 2'd0;
    new_tlb_info      = '0;
    test_reset();
    test_basic_hit();
    test_thread_isolation();
    test_supervisor();
    test_eviction();
    test_back_to_back();
    test_reset_with_install();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
